// File: rtl/npu_os_sequencer_if.sv
// Bundle of config, control and status signals between the NPU decoder side and the OS sequencer.
// The sequencer uses the slave modport; the decoder/driver side uses master.
interface npu_os_sequencer_if #(
   parameter int ARRAY_N    = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int K_WIDTH    = 16
);
   localparam int DW = $clog2(ARRAY_N) + 1;

   logic                  start_i;
   logic                  abort_i;
   logic [K_WIDTH-1:0]    k_len_i;
   logic [DW-1:0]         num_rows_i;
   logic [DW-1:0]         num_cols_i;
   logic [ADDR_WIDTH-1:0] a_base_addr_i;
   logic [ADDR_WIDTH-1:0] w_base_addr_i;
   logic [ADDR_WIDTH-1:0] o_base_addr_i;
   logic                  a_buf_on_o;
   logic                  w_buf_on_o;
   logic [ADDR_WIDTH-1:0] a_base_addr_o;
   logic [ADDR_WIDTH-1:0] w_base_addr_o;
   logic [ADDR_WIDTH-1:0] o_base_addr_o;
   logic [DW-1:0]         a_num_rows_o;
   logic [DW-1:0]         w_num_cols_o;
   logic [2:0]            operation_signal_o;
   logic                  o_ag_o_on_o;
   logic                  sa_reset_o;
   logic                  busy_o;
   logic                  done_o;
   logic                  err_o;
   logic [31:0]           perf_cycles_o;

   modport slave (
      input  start_i, abort_i, k_len_i, num_rows_i, num_cols_i,
             a_base_addr_i, w_base_addr_i, o_base_addr_i,
      output a_buf_on_o, w_buf_on_o, a_base_addr_o, w_base_addr_o, o_base_addr_o,
             a_num_rows_o, w_num_cols_o, operation_signal_o, o_ag_o_on_o,
             sa_reset_o, busy_o, done_o, err_o, perf_cycles_o
   );

   modport master (
      output start_i, abort_i, k_len_i, num_rows_i, num_cols_i,
             a_base_addr_i, w_base_addr_i, o_base_addr_i,
      input  a_buf_on_o, w_buf_on_o, a_base_addr_o, w_base_addr_o, o_base_addr_o,
             a_num_rows_o, w_num_cols_o, operation_signal_o, o_ag_o_on_o,
             sa_reset_o, busy_o, done_o, err_o, perf_cycles_o
   );
endinterface

// File: rtl/npu_os_sequencer.sv
// Output-stationary matmul pass sequencer: FLOW -> FLUSH -> DRAIN -> STORE -> CLEAR -> DONE.
// Optional pass cycle counter enabled by defining NPU_SEQ_PERF_CNT_EN.
module npu_os_sequencer #(
   parameter int ARRAY_N    = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int K_WIDTH    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   npu_os_sequencer_if.slave     bus
);
   localparam int DW = $clog2(ARRAY_N) + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FLOW  = 3'd1;
   localparam logic [2:0] S_FLUSH = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_STORE = 3'd4;
   localparam logic [2:0] S_CLEAR = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   localparam logic [2:0] OP_IDLE  = 3'b000;
   localparam logic [2:0] OP_FLOW  = 3'b100;
   localparam logic [2:0] OP_DRAIN = 3'b110;

   localparam logic [DW-1:0] L_DIM_MAX = DW'(ARRAY_N);

   logic [2:0]            r_state, w_state_next;
   logic [K_WIDTH-1:0]    r_cnt, w_cnt_next;
   logic                  r_abort_seen, w_abort_seen_next;
   logic [K_WIDTH-1:0]    r_k;
   logic [DW-1:0]         r_m, r_n;
   logic [ADDR_WIDTH-1:0] r_a_base, r_w_base, r_o_base;
   logic                  r_buf_on, r_o_ag, r_sa_reset, r_busy, r_done, r_err;
   logic [2:0]            r_op;

   logic                  w_cfg_ok, w_accept, w_abortable;
   logic [K_WIDTH-1:0]    w_m_ext, w_n_ext;
   logic [K_WIDTH-1:0]    w_flow_last, w_flush_last, w_drain_last, w_store_last;

   assign w_cfg_ok = (bus.num_rows_i != '0) && (bus.num_rows_i <= L_DIM_MAX) &&
                     (bus.num_cols_i != '0) && (bus.num_cols_i <= L_DIM_MAX) &&
                     (bus.k_len_i != '0);
   assign w_accept = (r_state == S_IDLE) && bus.start_i && w_cfg_ok;
   assign w_abortable = (r_state == S_FLOW) || (r_state == S_FLUSH) ||
                        (r_state == S_DRAIN) || (r_state == S_STORE);

   // Last counter value of each phase, derived from the latched config only.
   assign w_m_ext      = K_WIDTH'(r_m);
   assign w_n_ext      = K_WIDTH'(r_n);
   assign w_flow_last  = r_k - K_WIDTH'(1);
   assign w_flush_last = w_m_ext + w_n_ext - K_WIDTH'(2);
   assign w_drain_last = K_WIDTH'(ARRAY_N) - w_m_ext - K_WIDTH'(1);
   assign w_store_last = w_m_ext;

   always_comb begin
      w_state_next      = r_state;
      w_abort_seen_next = r_abort_seen;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next      = S_FLOW;
               w_abort_seen_next = 1'b0;
            end
         end
         S_FLOW:  if (r_cnt == w_flow_last)  w_state_next = S_FLUSH;
         S_FLUSH: if (r_cnt == w_flush_last) w_state_next = (r_m == L_DIM_MAX) ? S_STORE : S_DRAIN;
         S_DRAIN: if (r_cnt == w_drain_last) w_state_next = S_STORE;
         S_STORE: if (r_cnt == w_store_last) w_state_next = S_CLEAR;
         S_CLEAR: w_state_next = r_abort_seen ? S_IDLE : S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
      // Abort overrides any phase advance decided above.
      if (bus.abort_i && w_abortable) begin
         w_state_next      = S_CLEAR;
         w_abort_seen_next = 1'b1;
      end
      w_cnt_next = ((w_state_next != r_state) || (r_state == S_IDLE)) ? '0 : r_cnt + K_WIDTH'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_abort_seen <= 1'b0;
         r_k          <= '0;
         r_m          <= '0;
         r_n          <= '0;
         r_a_base     <= '0;
         r_w_base     <= '0;
         r_o_base     <= '0;
         r_buf_on     <= 1'b0;
         r_op         <= OP_IDLE;
         r_o_ag       <= 1'b0;
         r_sa_reset   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_abort_seen <= w_abort_seen_next;
         if (w_accept) begin
            r_k      <= bus.k_len_i;
            r_m      <= bus.num_rows_i;
            r_n      <= bus.num_cols_i;
            r_a_base <= bus.a_base_addr_i;
            r_w_base <= bus.w_base_addr_i;
            r_o_base <= bus.o_base_addr_i;
         end
         r_buf_on   <= (w_state_next == S_FLOW);
         r_op       <= ((w_state_next == S_FLOW) || (w_state_next == S_FLUSH)) ? OP_FLOW :
                       (w_state_next == S_DRAIN) ? OP_DRAIN : OP_IDLE;
         r_o_ag     <= (w_state_next == S_STORE);
         r_sa_reset <= (w_state_next == S_CLEAR);
         r_busy     <= (w_state_next != S_IDLE);
         r_done     <= (w_state_next == S_DONE);
         r_err      <= (r_state == S_IDLE) && bus.start_i && !w_cfg_ok;
      end
   end

`ifdef NPU_SEQ_PERF_CNT_EN
   logic [31:0] r_perf;

   // Loaded with 1 on acceptance so the first FLOW cycle is already counted.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_perf <= '0;
      end else if (w_accept) begin
         r_perf <= 32'd1;
      end else if ((w_state_next != S_IDLE) && (r_perf != '1)) begin
         r_perf <= r_perf + 32'd1;
      end
   end

   assign bus.perf_cycles_o = r_perf;
`else
   assign bus.perf_cycles_o = '0;
`endif

   assign bus.a_buf_on_o         = r_buf_on;
   assign bus.w_buf_on_o         = r_buf_on;
   assign bus.a_base_addr_o      = r_a_base;
   assign bus.w_base_addr_o      = r_w_base;
   assign bus.o_base_addr_o      = r_o_base;
   assign bus.a_num_rows_o       = r_m;
   assign bus.w_num_cols_o       = r_n;
   assign bus.operation_signal_o = r_op;
   assign bus.o_ag_o_on_o        = r_o_ag;
   assign bus.sa_reset_o         = r_sa_reset;
   assign bus.busy_o             = r_busy;
   assign bus.done_o             = r_done;
   assign bus.err_o              = r_err;
endmodule

// File: tb/tb_npu_os_sequencer.sv
// Randomized bench for npu_os_sequencer against a phase-arithmetic reference model.
// Expects perf_cycles_o to count only when NPU_SEQ_PERF_CNT_EN is defined.
module tb_npu_os_sequencer;
   localparam int AN = 16;
   localparam int AW = 32;
   localparam int KW = 10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   npu_os_sequencer_if #(.ARRAY_N(AN), .ADDR_WIDTH(AW), .K_WIDTH(KW)) sq_if ();

   npu_os_sequencer #(.ARRAY_N(AN), .ADDR_WIDTH(AW), .K_WIDTH(KW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (sq_if)
   );

   int n_vec = 0;
   int n_err = 0;
   int txn   = 0;

   logic [AW-1:0] exp_a, exp_w, exp_o;
   logic [4:0]    exp_m, exp_n;
   logic [31:0]   exp_perf;
   logic [9:0]    obs_ctl;

   assign obs_ctl = {sq_if.a_buf_on_o, sq_if.w_buf_on_o, sq_if.operation_signal_o,
                     sq_if.o_ag_o_on_o, sq_if.sa_reset_o, sq_if.busy_o, sq_if.done_o,
                     sq_if.err_o};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s txn=%0d t=%0t: got %0h expected %0h", tag, txn, $time, obs, exp);
      end
   endtask

   // Expected {a_on,w_on,op,o_ag,sa_reset,busy,done,err} in cycle t after acceptance.
   function automatic logic [9:0] ref_ctl(input int k, input int m, input int n,
                                          input int ab, input int t);
      int f_end, fl_end, dr_end, st_end, clr, dn;
      logic on, oag, sar, busy, dne;
      logic [2:0] op;
      on = 1'b0; oag = 1'b0; sar = 1'b0; busy = 1'b0; dne = 1'b0; op = 3'b000;
      f_end  = k;
      fl_end = f_end + m + n - 1;
      dr_end = fl_end + (AN - m);
      st_end = dr_end + m + 1;
      clr    = st_end + 1;
      dn     = clr + 1;
      if (ab > 0 && t > ab) begin
         if (t == ab + 1) begin sar = 1'b1; busy = 1'b1; end
      end else if (t >= 1 && t <= f_end) begin
         on = 1'b1; op = 3'b100; busy = 1'b1;
      end else if (t <= fl_end) begin
         op = 3'b100; busy = 1'b1;
      end else if (t <= dr_end) begin
         op = 3'b110; busy = 1'b1;
      end else if (t <= st_end) begin
         oag = 1'b1; busy = 1'b1;
      end else if (t == clr) begin
         sar = 1'b1; busy = 1'b1;
      end else if (t == dn) begin
         dne = 1'b1; busy = 1'b1;
      end
      return {on, on, op, oag, sar, busy, dne, 1'b0};
   endfunction

   task automatic check_cfg();
      check("a_base", sq_if.a_base_addr_o, exp_a);
      check("w_base", sq_if.w_base_addr_o, exp_w);
      check("o_base", sq_if.o_base_addr_o, exp_o);
      check("rows", sq_if.a_num_rows_o, exp_m);
      check("cols", sq_if.w_num_cols_o, exp_n);
`ifdef NPU_SEQ_PERF_CNT_EN
      check("perf", sq_if.perf_cycles_o, exp_perf);
`else
      check("perf", sq_if.perf_cycles_o, 0);
`endif
   endtask

   task automatic drive_noise();
      sq_if.start_i       = 1'($urandom_range(0, 1));
      sq_if.k_len_i       = KW'($urandom);
      sq_if.num_rows_i    = 5'($urandom_range(0, 31));
      sq_if.num_cols_i    = 5'($urandom_range(0, 31));
      sq_if.a_base_addr_i = $urandom;
      sq_if.w_base_addr_i = $urandom;
      sq_if.o_base_addr_i = $urandom;
   endtask

   // Starts at a negedge in IDLE; ends at a negedge in IDLE.
   task automatic run_pass(input int k, input int m, input int n, input int ab,
                           input bit noise, input int rst_at);
      int dn, t_end;
      logic [9:0] e;
      txn++;
      $display("txn %0d: pass K=%0d M=%0d N=%0d abort_at=%0d noise=%0d rst_at=%0d",
               txn, k, m, n, ab, noise, rst_at);
      dn = k + n + AN + m + 2;
      t_end = (rst_at > 0) ? rst_at + 1 : (ab > 0) ? ab + 2 : dn + 1;
      sq_if.start_i       = 1'b1;
      sq_if.abort_i       = 1'($urandom_range(0, 1));
      sq_if.k_len_i       = KW'(k);
      sq_if.num_rows_i    = 5'(m);
      sq_if.num_cols_i    = 5'(n);
      sq_if.a_base_addr_i = $urandom;
      sq_if.w_base_addr_i = $urandom;
      sq_if.o_base_addr_i = $urandom;
      exp_a = sq_if.a_base_addr_i;
      exp_w = sq_if.w_base_addr_i;
      exp_o = sq_if.o_base_addr_i;
      exp_m = 5'(m);
      exp_n = 5'(n);
      for (int t = 1; t <= t_end; t++) begin
         @(negedge clk);
         if (rst_at > 0 && t == rst_at + 1) begin
            exp_a = '0; exp_w = '0; exp_o = '0; exp_m = '0; exp_n = '0; exp_perf = '0;
            check("ctl_rst", obs_ctl, 0);
            check_cfg();
            rst_n = 1'b1;
         end else begin
            e = ref_ctl(k, m, n, ab, t);
            if (e[2]) exp_perf = 32'(t);
            check("ctl", obs_ctl, e);
            check_cfg();
         end
         sq_if.start_i = 1'b0;
         sq_if.abort_i = 1'b0;
         if (t < t_end) begin
            if (noise) drive_noise();
            if (t == ab) sq_if.abort_i = 1'b1;
            else if (ab == 0 && (t == dn - 1 || t == dn)) sq_if.abort_i = 1'($urandom_range(0, 1));
            if (t == rst_at) rst_n = 1'b0;
         end else begin
            sq_if.abort_i = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic run_err(input int k, input int m, input int n);
      txn++;
      $display("txn %0d: illegal start K=%0d M=%0d N=%0d", txn, k, m, n);
      sq_if.start_i    = 1'b1;
      sq_if.abort_i    = 1'b0;
      sq_if.k_len_i    = KW'(k);
      sq_if.num_rows_i = 5'(m);
      sq_if.num_cols_i = 5'(n);
      sq_if.a_base_addr_i = $urandom;
      @(negedge clk);
      check("err_pulse", obs_ctl, 10'b00_000_0000_1);
      check_cfg();
      sq_if.start_i = 1'b0;
      @(negedge clk);
      check("err_clear", obs_ctl, 0);
   endtask

   initial begin
      int kind, k, m, n, ab, sel, st_start;
      rst_n = 1'b0;
      sq_if.start_i = 1'b0;
      sq_if.abort_i = 1'b0;
      sq_if.k_len_i = '0;
      sq_if.num_rows_i = '0;
      sq_if.num_cols_i = '0;
      sq_if.a_base_addr_i = '0;
      sq_if.w_base_addr_i = '0;
      sq_if.o_base_addr_i = '0;
      exp_a = '0; exp_w = '0; exp_o = '0; exp_m = '0; exp_n = '0; exp_perf = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ctl", obs_ctl, 0);
      check_cfg();
      rst_n = 1'b1;
      @(negedge clk);

      run_pass(4, 16, 16, 0, 1'b0, 0);
      run_pass(2, 4, 8, 0, 1'b0, 0);
      run_err(5, 0, 4);
      run_err(5, 4, 17);
      run_err(0, 4, 4);
      run_pass(4, 16, 16, 10, 1'b0, 0);
      run_pass(2, 4, 8, 0, 1'b1, 0);
      run_pass(2, 4, 8, 0, 1'b0, 27);
      run_pass(2, 4, 8, 0, 1'b0, 0);
      run_pass(1, 1, 1, 0, 1'b0, 0);
      run_pass((1 << KW) - 1, 16, 16, 0, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 4);
         k = $urandom_range(1, 24);
         m = $urandom_range(1, 16);
         n = $urandom_range(1, 16);
         case (kind)
            0: begin
               sel = $urandom_range(0, 3);
               if (sel == 0) run_err(k, 0, n);
               else if (sel == 1) run_err(k, m, $urandom_range(17, 31));
               else if (sel == 2) run_err(0, m, n);
               else run_err(k, $urandom_range(17, 31), n);
            end
            1: run_pass(k, m, n, 0, 1'b0, 0);
            2: begin
               ab = $urandom_range(1, k + n + AN + m);
               run_pass(k, m, n, ab, 1'($urandom_range(0, 1)), 0);
            end
            3: run_pass(k, m, n, 0, 1'b1, 0);
            default: begin
               st_start = k + n + AN;
               run_pass(k, m, n, 0, 1'b0, $urandom_range(st_start, st_start + m));
            end
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
